uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 serial receiver; receive-side counterpart of the SoC UART transmitter (uart_tx_wire).
//   - Synchronises the asynchronous rx line and recovers bytes by mid-bit sampling.
//   - Buffers bytes in a small first-word-fall-through FIFO for the memory-mapped RAM/IO block.
//   - The CPU polls data_valid and pops with rd_enable.
// PARAMETERS
//   CLK_FREQ     12000000  system clock frequency, Hz
//   BAUD_RATE    115200    line rate, bit/s
//   CLKS_PER_BIT CLK_FREQ/BAUD_RATE (integer truncation; 104 at defaults); derived, do not override
//   FIFO_AW      2         FIFO address width; depth = 2**FIFO_AW bytes
// PORTS
//   clk           in   1  system clock, all logic on posedge
//   rst           in   1  synchronous, active-high reset
//   uart_rx_wire  in   1  asynchronous serial input, idle high
//   rd_enable     in   1  pop FIFO head this cycle (ignored when data_valid=0)
//   err_clear     in   1  clear sticky frame_err and overrun
//   data_out      out  8  FIFO head byte; 8'h00 whenever data_valid=0
//   data_valid    out  1  FIFO not empty
//   frame_err     out  1  sticky: bad stop bit (or parity, see CONFIGURATION)
//   overrun       out  1  sticky: byte received while FIFO full, byte dropped
// BEHAVIOUR
//   Reset values: data_out=0, data_valid=0, frame_err=0, overrun=0; FIFO emptied; FSM in IDLE;
//     synchroniser flops and edge-detect history flop set to 1.
//   Reset mid-frame: partial byte discarded, nothing pushed.
//   Input sync: 2-flop synchroniser, then one history flop. Falling edge = history 1, sync 0.
//   FSM states and transitions:
//     IDLE  - on falling edge: go START, bit counter=0.
//     START - at count CLKS_PER_BIT/2-1, sample the line.
//             Line 0: go DATA, counter=0, bit_idx=0.
//             Line 1: glitch, return to IDLE; no flag set.
//     DATA  - each time counter reaches CLKS_PER_BIT-1: sample into shift[bit_idx] (LSB first),
//             counter=0. After bit_idx 7: go STOP (or PARITY when enabled).
//     STOP  - at count CLKS_PER_BIT-1, sample the line.
//             Line 1: push byte.
//             Line 0: set frame_err, drop byte.
//             Always return to IDLE. A new frame needs a fresh falling edge, so a held-low
//             line (break) never re-triggers.
//   Latency: data_valid rises the cycle after the stop-bit sample (byte pushed on that edge).
//   FIFO (FWFT):
//     - data_out = mem[rd_ptr] when not empty.
//     - Pointers are FIFO_AW+1 bits and wrap naturally; full/empty come from the MSB compare.
//     - rd_enable with data_valid=1: rd_ptr advances on that edge; data_out shows the next byte
//       on the following cycle.
//     - Push when full with no pop: byte dropped, overrun set.
//     - Push and pop in the same cycle: both succeed, count unchanged, including when full
//       (no overrun).
//     - Push and pop in the same cycle when empty: push only (pop ignored).
//   Sticky flags: err_clear and a new error in the same cycle -> set wins.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Adds state PARITY between DATA and STOP; one even-parity bit sampled at CLKS_PER_BIT-1.
//     - Mismatch: set frame_err, drop byte; STOP is still traversed before returning to IDLE.
//   UART_RX_PARITY_EN undefined: no PARITY state; the bit after data bit 7 is the stop bit.
// TESTING (defaults, 104 clk/bit)
//   1. Frame 0x55, good stop -> data_valid=1 one clk after stop sample, data_out=8'h55;
//      one rd_enable pulse -> data_valid=0, data_out=0 next clk.
//   2. Line low 20 clks then high -> no push, data_valid=0, frame_err=0, FSM back in IDLE.
//   3. Frame 0xA3 with stop=0 -> frame_err=1, data_valid=0;
//      pulse err_clear -> frame_err=0 next clk.
//   4. FIFO_AW=2: frames 0x01..0x05, no reads -> overrun=1;
//      4 pops return 0x01,0x02,0x03,0x04, then data_valid=0.
//   5. rst pulsed during data bit 4 of a frame -> no byte;
//      next frame 0x3C -> data_out=8'h3C, flags 0.
//   6. UART_RX_PARITY_EN: 0x07 with parity=1 -> received;
//      0x07 with parity=0 -> frame_err=1, no byte.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a 2**FIFO_AW-byte FWFT FIFO; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 115200,
    parameter int FIFO_AW   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_wire,
    input  logic       rd_enable,
    input  logic       err_clear,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic sync1_q, sync2_q, hist_q;
    logic frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0] mem_q [2**FIFO_AW];
    logic fall, push, frame_set, keep, empty, full, pop, wr_en;
`ifdef UART_RX_PARITY_EN
    logic drop_q, drop_d;
    assign keep = ~drop_q;
`else
    assign keep = 1'b1;
`endif
    assign fall = hist_q & ~sync2_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d = shift_q;
        push = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        drop_d = drop_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
`ifdef UART_RX_PARITY_EN
                if (fall) drop_d = 1'b0;
`endif
            end
            START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_idx_d = '0;
                state_d = sync2_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                shift_d[bit_idx_q] = sync2_q;
                bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx_q == 3'd7) state_d = PARITY;
`else
                if (bit_idx_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_q == FULL) begin
                cnt_d = '0;
                state_d = STOP;
                frame_set = sync2_q != ^shift_q;
                drop_d = sync2_q != ^shift_q;
            end
`endif
            STOP: if (cnt_q == FULL) begin
                cnt_d = '0;
                state_d = IDLE;
                push = sync2_q & keep;
                frame_set = ~sync2_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // a pop only counts when there is something to pop, which also frees a slot for a same-cycle push
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) && (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop = rd_enable & ~empty;
    assign wr_en = push & (~full | pop);
    assign wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(wr_en);
    assign rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);
    assign overrun_d = (overrun_q & ~err_clear) | (push & full & ~pop);
    assign frame_err_d = (frame_err_q & ~err_clear) | frame_set;
    assign data_valid = ~empty;
    assign data_out = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign frame_err = frame_err_q;
    assign overrun = overrun_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef UART_RX_PARITY_EN
            drop_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q <= shift_d;
            sync1_q <= uart_rx_wire;
            sync2_q <= sync1_q;
            hist_q <= sync2_q;
            frame_err_q <= frame_err_d;
            overrun_q <= overrun_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef UART_RX_PARITY_EN
            drop_q <= drop_d;
`endif
            if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 104 clk/bit against hand-computed expectations
module tb_uart_rx;
    localparam int CPB = 104;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_enable = 1'b0, err_clear = 1'b0;
    logic [7:0] data_out;
    logic data_valid, frame_err, overrun;
    int n_checks = 0, n_fail = 0;

    uart_rx dut (
        .clk(clk), .rst(rst), .uart_rx_wire(rx), .rd_enable(rd_enable), .err_clear(err_clear),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit(par_b);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_head(d, par_b);
        drive_bit(stop_b);
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd_enable = 1'b1;
        @(negedge clk);
        rd_enable = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_valid", data_valid, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        // stop sample lands 55 clocks into the stop bit; data_valid follows one clock later
        send_head(8'h55, 1'b0);
        rx = 1'b1;
        repeat (54) @(negedge clk);
        check_eq("t1_valid_before", data_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_valid_after", data_valid, 1'b1);
        check_eq("t1_data", data_out, 8'h55);
        repeat (69) @(negedge clk);
        pulse_rd();
        check_eq("t1_pop_valid", data_valid, 1'b0);
        check_eq("t1_pop_data", data_out, 8'h00);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("t2_valid", data_valid, 1'b0);
        check_eq("t2_frame_err", frame_err, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        check_eq("t3_frame_err", frame_err, 1'b1);
        check_eq("t3_valid", data_valid, 1'b0);
        pulse_clear();
        check_eq("t3_cleared", frame_err, 1'b0);
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, ^8'(i));
        check_eq("t4_overrun", overrun, 1'b1);
        check_eq("t4_valid", data_valid, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("t4_pop%0d", i), data_out, 8'(i));
            pulse_rd();
        end
        check_eq("t4_empty_valid", data_valid, 1'b0);
        check_eq("t4_empty_data", data_out, 8'h00);
        check_eq("t4_frame_err", frame_err, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check_eq("t5_valid", data_valid, 1'b0);
        check_eq("t5_overrun", overrun, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        check_eq("t5_data", data_out, 8'h3C);
        check_eq("t5_valid2", data_valid, 1'b1);
        check_eq("t5_frame_err", frame_err, 1'b0);
        check_eq("t5_overrun2", overrun, 1'b0);
        pulse_rd();
`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        check_eq("t6_good_valid", data_valid, 1'b1);
        check_eq("t6_good_data", data_out, 8'h07);
        check_eq("t6_good_err", frame_err, 1'b0);
        pulse_rd();
        send(8'h07, 1'b1, 1'b0);
        check_eq("t6_bad_err", frame_err, 1'b1);
        check_eq("t6_bad_valid", data_valid, 1'b0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
